// File: rtl/seven_segment_scanner_if.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner_if
//   Bundles the BCD digit inputs and the display pin outputs of the
//   seven-segment scanner.
//   master : digit source / observer (drives digits, reads display pins)
//   slave  : the scanner itself (reads digits, drives display pins)
//   Signals:
//     digit4..digit0 : BCD digits, digit4 most significant
//     blank_zeros    : leading-zero blanking enable
//     segments       : {g,f,e,d,c,b,a}, active-low
//     anodes         : anodes[i] enables digit i, active-low
//     frame_start    : one-cycle pulse on first DRIVE cycle of digit4
// ---------------------------------------------------------------------------
interface seven_segment_scanner_if;
    logic [3:0] digit4;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       blank_zeros;
    logic [6:0] segments;
    logic [4:0] anodes;
    logic       frame_start;

    modport master (
        output digit4, digit3, digit2, digit1, digit0, blank_zeros,
        input  segments, anodes, frame_start
    );

    modport slave (
        input  digit4, digit3, digit2, digit1, digit0, blank_zeros,
        output segments, anodes, frame_start
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner
//   Time-multiplexes five BCD digits onto a common-anode 5-digit
//   seven-segment display. All digits (and the blanking enable) are
//   snapshotted once per frame so a mid-frame change never tears the number.
//   Each digit is preceded by an all-off gap to suppress ghosting.
//   Ports:
//     clock : system clock, rising edge
//     reset : synchronous, active-high
//     bus   : seven_segment_scanner_if.slave (digits in, segments/anodes out)
//   Parameters:
//     DIGIT_CYCLES : cycles each digit is driven (>= 1)
//     BLANK_CYCLES : all-off cycles before each digit (>= 1)
// ---------------------------------------------------------------------------
module seven_segment_scanner #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    seven_segment_scanner_if.slave  bus
);
    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {GAP, DRIVE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      scan_reg, scan_next;
    logic [4:0][3:0] snap_reg, snap_next;
    logic            blank_reg, blank_next;
    logic [6:0]      seg_reg, seg_next;
    logic [4:0]      an_reg, an_next;
    logic            fs_reg, fs_next;

    logic [4:0][3:0] digits_in;
    logic [4:0]      blanked;

    assign digits_in = {bus.digit4, bus.digit3, bus.digit2, bus.digit1, bus.digit0};

    // Active-low {g..a} pattern; 10..15 render as a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // Position gi is blanked when it and every more significant snapshot
    // digit are zero. Evaluated on the next-cycle snapshot so the registered
    // outputs line up with the state they belong to. Digit0 always shows.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blanked[gi] = 1'b0;
            end else begin : g_upper
                assign blanked[gi] = blank_next & ~|snap_next[4:gi];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        scan_next  = scan_reg;
        snap_next  = snap_reg;
        blank_next = blank_reg;
        fs_next    = 1'b0;

        case (state_reg)
            GAP: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                    if (scan_reg == 3'd4) begin
                        snap_next  = digits_in;
                        blank_next = bus.blank_zeros;
                        fs_next    = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt_reg == DIGIT_LAST) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    scan_next  = (scan_reg == 3'd0) ? 3'd4 : scan_reg - 3'd1;
                end
            end
            default: begin
                state_next = GAP;
                cnt_next   = '0;
            end
        endcase

        // Outputs are computed for the upcoming state so they can be registered.
        seg_next = 7'h7f;
        an_next  = 5'h1f;
        if (state_next == DRIVE) begin
            for (int i = 0; i < 5; i++) begin
                if (scan_next == 3'(i) && !blanked[i]) begin
                    an_next[i] = 1'b0;
                    seg_next   = decode(snap_next[i]);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= GAP;
            cnt_reg   <= '0;
            scan_reg  <= 3'd4;
            snap_reg  <= '0;
            blank_reg <= 1'b0;
            seg_reg   <= 7'h7f;
            an_reg    <= 5'h1f;
            fs_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            scan_reg  <= scan_next;
            snap_reg  <= snap_next;
            blank_reg <= blank_next;
            seg_reg   <= seg_next;
            an_reg    <= an_next;
            fs_reg    <= fs_next;
        end
    end

    assign bus.segments    = seg_reg;
    assign bus.anodes      = an_reg;
    assign bus.frame_start = fs_reg;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scanner
//   Directed bench for seven_segment_scanner with DIGIT_CYCLES=4,
//   BLANK_CYCLES=2 (digit period 6, frame period 30). Each frame is walked
//   cycle by cycle against hand-computed segment/anode patterns.
// ---------------------------------------------------------------------------
module tb_seven_segment_scanner;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    seven_segment_scanner_if u_if ();

    seven_segment_scanner #(
        .DIGIT_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clock(clk),
        .reset(reset),
        .bus  (u_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_digits(input logic [19:0] d, input logic bz);
        u_if.digit4      = d[19:16];
        u_if.digit3      = d[15:12];
        u_if.digit2      = d[11:8];
        u_if.digit1      = d[7:4];
        u_if.digit0      = d[3:0];
        u_if.blank_zeros = bz;
    endtask

    task automatic check_gap(input string tag);
        check_val({tag, " an"},  u_if.anodes,      5'h1f);
        check_val({tag, " seg"}, u_if.segments,    7'h7f);
        check_val({tag, " fs"},  u_if.frame_start, 1'b0);
    endtask

    // Called at the sample point of a frame's first DRIVE cycle; returns at
    // the sample point of the following frame's first DRIVE cycle.
    // segs_exp holds {p4,p3,p2,p1,p0}; on_mask bit p=0 means position p blank.
    task automatic check_frame(input string name, input logic [34:0] segs_exp,
                               input logic [4:0] on_mask, input bit chg,
                               input logic [19:0] chg_d, input logic chg_bz);
        for (int p = 4; p >= 0; p--) begin
            for (int c = 0; c < 4; c++) begin
                if (chg && p == 2 && c == 0) set_digits(chg_d, chg_bz);
                check_val($sformatf("%s fs p%0d c%0d", name, p, c), u_if.frame_start,
                          (p == 4 && c == 0) ? 1 : 0);
                check_val($sformatf("%s an p%0d", name, p), u_if.anodes,
                          on_mask[p] ? (5'h1f & ~(5'd1 << p)) : 5'h1f);
                check_val($sformatf("%s seg p%0d", name, p), u_if.segments,
                          on_mask[p] ? segs_exp[p*7 +: 7] : 7'h7f);
                tick();
            end
            for (int c = 0; c < 2; c++) begin
                check_gap($sformatf("%s gap p%0d", name, p));
                tick();
            end
        end
        $display("frame %s checked, checks=%0d", name, checks);
    endtask

    initial begin
        int n;
        set_digits(20'h00000, 1'b0);

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_gap($sformatf("reset c%0d", i));
        end
        reset = 1'b0;
        tick();
        check_gap("post-reset gap");
        tick();
        check_val("first fs", u_if.frame_start, 1'b1);
        check_val("first an", u_if.anodes,      5'b01111);
        $display("reset release done, checks=%0d", checks);

        // Zeros, blanking off: every position shows 0.
        set_digits(20'h00000, 1'b1);
        check_frame("zeros_noblank", {5{7'h40}}, 5'b11111, 1'b0, 20'h0, 1'b0);

        // Zeros, blanking on: only digit0 lit.
        set_digits(20'h01234, 1'b1);
        check_frame("zeros_blank", {5{7'h40}}, 5'b00001, 1'b0, 20'h0, 1'b0);

        // 0,1,2,3,4 with blanking: digit4 dark.
        set_digits(20'h00A00, 1'b1);
        check_frame("01234", {7'h7f, 7'h79, 7'h24, 7'h30, 7'h19}, 5'b01111, 1'b0, 20'h0, 1'b0);

        // Digit2 = A: dash, lower zeros shown, upper zeros blanked.
        set_digits(20'h11111, 1'b0);
        check_frame("dash", {7'h7f, 7'h7f, 7'h3f, 7'h40, 7'h40}, 5'b00111, 1'b0, 20'h0, 1'b0);

        // 1s frame with inputs switched to 2s mid-frame: no tearing.
        check_frame("ones_torn", {5{7'h79}}, 5'b11111, 1'b1, 20'h22222, 1'b0);
        check_frame("twos", {5{7'h24}}, 5'b11111, 1'b0, 20'h0, 1'b0);

        // Advance into the second DRIVE cycle of digit1, then pulse reset.
        for (int i = 0; i < 19; i++) tick();
        check_val("pre-reset an",  u_if.anodes,   5'b11101);
        check_val("pre-reset seg", u_if.segments, 7'h24);
        reset = 1'b1;
        tick();
        check_gap("mid reset");
        reset = 1'b0;
        tick();
        check_gap("restart gap");
        tick();
        check_val("restart fs",  u_if.frame_start, 1'b1);
        check_val("restart an",  u_if.anodes,      5'b01111);
        check_val("restart seg", u_if.segments,    7'h24);

        // Frame-start spacing, bounded wait.
        n = 0;
        do begin
            tick();
            n++;
        end while (u_if.frame_start !== 1'b1 && n < 40);
        check_val("fs interval", n, 30);
        $display("reset restart done, checks=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
